// File: rtl/mem_stage_sram_if.sv
// -----------------------------------------------------------------------------
// mem_stage_sram_if
// Bundles every non-clock signal of the memory stage into one interface.
//   EX/MEM side   : WB_EN, MEM_R_EN, MEM_W_EN, ALU_Res, Val_Rm, Dest
//   Stall         : freeze (to upstream stages)
//   SRAM side     : sram_addr, sram_dq_out, sram_dq_in, sram_we_n
//   MEM/WB side   : WB_EN_out, MEM_R_EN_out, ALU_Res_out, Mem_Data_out, Dest_out
// Modports:
//   slave  - the memory stage itself
//   master - the surroundings (pipeline, SRAM and write-back)
// -----------------------------------------------------------------------------
interface mem_stage_sram_if #(
  parameter int ADDR_W = 17
);
  logic              WB_EN;
  logic              MEM_R_EN;
  logic              MEM_W_EN;
  logic [31:0]       ALU_Res;
  logic [31:0]       Val_Rm;
  logic [3:0]        Dest;

  logic              freeze;

  logic [ADDR_W:0]   sram_addr;
  logic [15:0]       sram_dq_out;
  logic [15:0]       sram_dq_in;
  logic              sram_we_n;

  logic              WB_EN_out;
  logic              MEM_R_EN_out;
  logic [31:0]       ALU_Res_out;
  logic [31:0]       Mem_Data_out;
  logic [3:0]        Dest_out;

  modport slave (
    input  WB_EN, MEM_R_EN, MEM_W_EN, ALU_Res, Val_Rm, Dest, sram_dq_in,
    output freeze, sram_addr, sram_dq_out, sram_we_n,
    output WB_EN_out, MEM_R_EN_out, ALU_Res_out, Mem_Data_out, Dest_out
  );

  modport master (
    output WB_EN, MEM_R_EN, MEM_W_EN, ALU_Res, Val_Rm, Dest, sram_dq_in,
    input  freeze, sram_addr, sram_dq_out, sram_we_n,
    input  WB_EN_out, MEM_R_EN_out, ALU_Res_out, Mem_Data_out, Dest_out
  );
endinterface

// File: rtl/mem_stage_sram.sv
// -----------------------------------------------------------------------------
// mem_stage_sram
// Memory stage of the 5-stage pipeline. Loads and stores 32-bit words against
// a 16-bit asynchronous SRAM as two half-word accesses (low half first), each
// lasting WAIT_CYCLES clocks, while holding freeze high to stall upstream.
// Also holds the MEM/WB pipeline register.
// Ports:
//   clk  - pipeline clock
//   rst  - asynchronous reset, active low
//   bus  - mem_stage_sram_if.slave (EX/MEM inputs, freeze, SRAM pins, MEM/WB)
// Parameters:
//   WAIT_CYCLES - clocks per half-word access (>= 1)
//   ADDR_W      - SRAM word-address width (half-word address is ADDR_W+1)
//   BASE_ADDR   - byte address that maps to SRAM word 0
// -----------------------------------------------------------------------------
module mem_stage_sram #(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 17,
  parameter int BASE_ADDR   = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_stage_sram_if.slave      bus
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_count;
  logic [ADDR_W-1:0]   r_wordAddr;
  logic [31:0]         r_data;
  logic                r_write;
  logic [15:0]         r_lo;
  logic [15:0]         r_hi;

  logic                r_wbEnOut;
  logic                r_memREnOut;
  logic [31:0]         r_aluResOut;
  logic [31:0]         r_memDataOut;
  logic [3:0]          r_destOut;

  logic                w_req;
  logic                w_loadReq;
  logic [31:0]         w_offset;
  logic [ADDR_W-1:0]   w_wordAddr;
  logic                w_lastCount;
  logic                w_freeze;
  logic                w_unusedOffsetBits;

  // A store wins over a load when both enables are set.
  assign w_req       = bus.MEM_R_EN | bus.MEM_W_EN;
  assign w_loadReq   = bus.MEM_R_EN & ~bus.MEM_W_EN;

  // Byte offsets into the SRAM window; the two low bits are simply dropped,
  // so misaligned addresses silently round down to the containing word.
  assign w_offset           = bus.ALU_Res - 32'(BASE_ADDR);
  assign w_wordAddr         = w_offset[ADDR_W+1:2];
  assign w_unusedOffsetBits = ^{w_offset[31:ADDR_W+2], w_offset[1:0]};

  assign w_lastCount = (r_count == CNT_W'(WAIT_CYCLES - 1));

  // DONE deliberately drops freeze so the instruction retires exactly once.
  assign w_freeze   = ((r_state == IDLE) & w_req) | (r_state == LO) | (r_state == HI);
  assign bus.freeze = w_freeze;

  // Access sequencer: captures the request, then walks the low and high
  // halves, sampling read data on the edge that ends each half.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_count    <= '0;
      r_wordAddr <= '0;
      r_data     <= '0;
      r_write    <= 1'b0;
      r_lo       <= '0;
      r_hi       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_count <= '0;
          if (w_req) begin
            r_wordAddr <= w_wordAddr;
            r_data     <= bus.Val_Rm;
            r_write    <= bus.MEM_W_EN;
            r_state    <= LO;
          end
        end
        LO: begin
          if (w_lastCount) begin
            r_lo    <= bus.sram_dq_in;
            r_count <= '0;
            r_state <= HI;
          end else begin
            r_count <= r_count + 1'b1;
          end
        end
        HI: begin
          if (w_lastCount) begin
            r_hi    <= bus.sram_dq_in;
            r_count <= '0;
            r_state <= DONE;
          end else begin
            r_count <= r_count + 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // SRAM pins are decoded from the registered state so a reset releases the
  // write strobe at once; outside an access the bus sits at zero.
  always_comb begin
    bus.sram_addr   = '0;
    bus.sram_dq_out = '0;
    bus.sram_we_n   = 1'b1;
    case (r_state)
      LO: begin
        bus.sram_addr   = {r_wordAddr, 1'b0};
        bus.sram_dq_out = r_data[15:0];
        bus.sram_we_n   = ~r_write;
      end
      HI: begin
        bus.sram_addr   = {r_wordAddr, 1'b1};
        bus.sram_dq_out = r_data[31:16];
        bus.sram_we_n   = ~r_write;
      end
      default: begin
      end
    endcase
  end

  // MEM/WB register: a stalled cycle inserts a bubble, otherwise the stage
  // inputs advance. Load data is only refreshed as a load retires from DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wbEnOut    <= 1'b0;
      r_memREnOut  <= 1'b0;
      r_aluResOut  <= '0;
      r_memDataOut <= '0;
      r_destOut    <= '0;
    end else if (w_freeze) begin
      r_wbEnOut   <= 1'b0;
      r_memREnOut <= 1'b0;
    end else begin
      r_wbEnOut   <= bus.WB_EN;
      r_memREnOut <= w_loadReq;
      r_aluResOut <= bus.ALU_Res;
      r_destOut   <= bus.Dest;
      if ((r_state == DONE) && !r_write) begin
        r_memDataOut <= {r_hi, r_lo};
      end
    end
  end

  assign bus.WB_EN_out    = r_wbEnOut;
  assign bus.MEM_R_EN_out = r_memREnOut;
  assign bus.ALU_Res_out  = r_aluResOut;
  assign bus.Mem_Data_out = r_memDataOut;
  assign bus.Dest_out     = r_destOut;

endmodule

// File: tb/tb_mem_stage_sram.sv
// -----------------------------------------------------------------------------
// tb_mem_stage_sram
// Directed bench for mem_stage_sram with a 16-entry behavioural SRAM and a
// queue of expected MEM/WB contents.
// -----------------------------------------------------------------------------
module tb_mem_stage_sram;

  localparam int WAIT_CYCLES = 2;
  localparam int ADDR_W      = 17;
  localparam int BASE_ADDR   = 1024;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  mem_stage_sram_if #(.ADDR_W(ADDR_W)) bus ();

  mem_stage_sram #(
    .WAIT_CYCLES(WAIT_CYCLES),
    .ADDR_W     (ADDR_W),
    .BASE_ADDR  (BASE_ADDR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Behavioural SRAM: combinational read, write on each clock the strobe is low.
  logic [15:0] sram [16] = '{default: 16'h0000};
  logic        preload   = 1'b0;
  int          wrCnt     = 0;

  assign bus.sram_dq_in = sram[bus.sram_addr[3:0]];

  always @(posedge clk) begin
    if (!bus.sram_we_n) begin
      sram[bus.sram_addr[3:0]] <= bus.sram_dq_out;
      wrCnt <= wrCnt + 1;
    end else if (preload) begin
      sram[4] <= 16'h1234;
      sram[5] <= 16'hABCD;
    end
  end

  typedef struct {
    logic        wb;
    logic        mr;
    logic [31:0] alu;
    logic [31:0] mem;
    logic [3:0]  dest;
  } exp_t;

  exp_t        sbQ[$];
  logic [31:0] expMem = 32'h0;

  int vectors = 0;
  int errors  = 0;

  logic [ADDR_W:0] rAddr [8];
  logic [15:0]     rDq   [8];
  logic            rWe   [8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic driveBus(input logic wb, input logic mr, input logic mw,
                          input logic [31:0] alu, input logic [31:0] val,
                          input logic [3:0] dest);
    bus.WB_EN    = wb;
    bus.MEM_R_EN = mr;
    bus.MEM_W_EN = mw;
    bus.ALU_Res  = alu;
    bus.Val_Rm   = val;
    bus.Dest     = dest;
  endtask

  task automatic driveIdle();
    driveBus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  // Drives an instruction and records what MEM/WB must hold once it retires.
  task automatic applyStimulus(input logic wb, input logic mr, input logic mw,
                               input logic [31:0] alu, input logic [31:0] val,
                               input logic [3:0] dest, input logic [31:0] loadData);
    exp_t e;
    driveBus(wb, mr, mw, alu, val, dest);
    if (mr && !mw) expMem = loadData;
    e.wb   = wb;
    e.mr   = mr & ~mw;
    e.alu  = alu;
    e.mem  = expMem;
    e.dest = dest;
    sbQ.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sbQ.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sbQ.pop_front();
      check("wb_en_out",    {31'h0, bus.WB_EN_out},    {31'h0, e.wb});
      check("mem_r_en_out", {31'h0, bus.MEM_R_EN_out}, {31'h0, e.mr});
      check("alu_res_out",  bus.ALU_Res_out,           e.alu);
      check("mem_data_out", bus.Mem_Data_out,          e.mem);
      check("dest_out",     {28'h0, bus.Dest_out},     {28'h0, e.dest});
    end
  endtask

  // Counts freeze cycles of one access, recording the SRAM pins each cycle.
  // Returns in the first freeze=0 cycle (DONE), or after a cycle budget.
  task automatic runAccess(output int fcnt);
    fcnt = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (!bus.freeze) break;
      if (fcnt < 8) begin
        rAddr[fcnt] = bus.sram_addr;
        rDq[fcnt]   = bus.sram_dq_out;
        rWe[fcnt]   = bus.sram_we_n;
      end
      if (fcnt > 0) check("bubble_wb_en", {31'h0, bus.WB_EN_out}, 32'h0);
      fcnt++;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int fc;
    int w0;

    // Reset held low mid-cycle
    driveIdle();
    rst = 1'b0;
    #12;
    check("rst_wb_en_out",    {31'h0, bus.WB_EN_out},    32'h0);
    check("rst_mem_r_en_out", {31'h0, bus.MEM_R_EN_out}, 32'h0);
    check("rst_alu_res_out",  bus.ALU_Res_out,           32'h0);
    check("rst_mem_data_out", bus.Mem_Data_out,          32'h0);
    check("rst_dest_out",     {28'h0, bus.Dest_out},     32'h0);
    check("rst_we_n",         {31'h0, bus.sram_we_n},    32'h1);
    check("rst_addr",         32'(bus.sram_addr),        32'h0);
    check("rst_dq_out",       {16'h0, bus.sram_dq_out},  32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Pass-through of a non-memory instruction
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h55, 32'h0, 4'd3, 32'h0);
    #1;
    check("pass_freeze", {31'h0, bus.freeze}, 32'h0);
    @(posedge clk);
    #1;
    checkOutput();
    driveIdle();

    // Store 0xDEADBEEF to byte 1032 -> half-words 4 and 5
    w0 = wrCnt;
    applyStimulus(1'b0, 1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 4'd0, 32'h0);
    runAccess(fc);
    check("st_freeze_cycles", fc, 32'd1 + 2 * WAIT_CYCLES);
    check("st_idle_we_n", {31'h0, rWe[0]}, 32'h1);
    for (int i = 1; i <= 2; i++) begin
      check("st_lo_addr", 32'(rAddr[i]),     32'd4);
      check("st_lo_dq",   {16'h0, rDq[i]},   32'hBEEF);
      check("st_lo_we_n", {31'h0, rWe[i]},   32'h0);
    end
    for (int i = 3; i <= 4; i++) begin
      check("st_hi_addr", 32'(rAddr[i]),     32'd5);
      check("st_hi_dq",   {16'h0, rDq[i]},   32'hDEAD);
      check("st_hi_we_n", {31'h0, rWe[i]},   32'h0);
    end
    @(posedge clk);
    #1;
    checkOutput();
    driveIdle();
    check("st_write_cycles", wrCnt - w0, 32'd4);
    check("st_sram_lo", {16'h0, sram[4]}, 32'hBEEF);
    check("st_sram_hi", {16'h0, sram[5]}, 32'hDEAD);

    // Load 0xABCD1234 from byte 1032 after restoring the SRAM contents
    preload = 1'b1;
    @(posedge clk);
    #1;
    preload = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd1032, 32'h0, 4'd7, 32'hABCD1234);
    runAccess(fc);
    check("ld_freeze_cycles", fc, 32'd1 + 2 * WAIT_CYCLES);
    @(posedge clk);
    #1;
    checkOutput();
    driveIdle();
    @(posedge clk);
    #1;
    check("ld_wb_pulse_end", {31'h0, bus.WB_EN_out}, 32'h0);

    // Both enables high: the store wins
    w0 = wrCnt;
    applyStimulus(1'b1, 1'b1, 1'b1, 32'd1036, 32'h0BADF00D, 4'd2, 32'h0);
    runAccess(fc);
    check("both_freeze_cycles", fc, 32'd1 + 2 * WAIT_CYCLES);
    check("both_we_n", {31'h0, rWe[1]}, 32'h0);
    @(posedge clk);
    #1;
    checkOutput();
    driveIdle();
    check("both_write_cycles", wrCnt - w0, 32'd4);
    check("both_sram_lo", {16'h0, sram[6]}, 32'hF00D);
    check("both_sram_hi", {16'h0, sram[7]}, 32'h0BAD);

    // Back-to-back load then store with a single DONE gap
    w0 = wrCnt;
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd1036, 32'h0, 4'd5, 32'h0BADF00D);
    runAccess(fc);
    check("b2b_ld_freeze_cycles", fc, 32'd1 + 2 * WAIT_CYCLES);
    @(posedge clk);
    #1;
    checkOutput();
    applyStimulus(1'b0, 1'b0, 1'b1, 32'd1044, 32'h13579BDF, 4'd0, 32'h0);
    #1;
    check("b2b_restart_freeze", {31'h0, bus.freeze}, 32'h1);
    runAccess(fc);
    check("b2b_st_freeze_cycles", fc, 32'd1 + 2 * WAIT_CYCLES);
    @(posedge clk);
    #1;
    checkOutput();
    driveIdle();
    @(posedge clk);
    @(posedge clk);
    #1;
    check("b2b_write_cycles", wrCnt - w0, 32'd4);
    check("b2b_idle_freeze", {31'h0, bus.freeze}, 32'h0);
    check("b2b_sram_lo", {16'h0, sram[10]}, 32'h9BDF);
    check("b2b_sram_hi", {16'h0, sram[11]}, 32'h1357);

    // Reset during the high half of a store aborts it
    driveBus(1'b0, 1'b0, 1'b1, 32'd1048, 32'hCAFEF00D, 4'd0);
    repeat (3) @(posedge clk);
    #1;
    check("abort_pre_addr", 32'(bus.sram_addr), 32'd13);
    check("abort_pre_we_n", {31'h0, bus.sram_we_n}, 32'h0);
    rst = 1'b0;
    #1;
    check("abort_we_n", {31'h0, bus.sram_we_n}, 32'h1);
    check("abort_addr", 32'(bus.sram_addr), 32'h0);
    check("abort_mem_data", bus.Mem_Data_out, 32'h0);
    driveIdle();
    #1;
    rst = 1'b1;
    #1;
    check("abort_freeze", {31'h0, bus.freeze}, 32'h0);
    @(posedge clk);
    #1;
    check("abort_freeze_next", {31'h0, bus.freeze}, 32'h0);
    check("abort_we_n_next", {31'h0, bus.sram_we_n}, 32'h1);
    check("abort_sram_lo", {16'h0, sram[12]}, 32'hF00D);
    check("abort_sram_hi", {16'h0, sram[13]}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
